mips_cpu_muldiv: RTL

- Multi-cycle multiply/divide unit for MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- Owns the architectural HI/LO registers and sequences a single shared 33-bit adder/subtractor, one radix-2 step per cycle.
- Sits beside the single-cycle ALU in the execute stage. The CPU control stalls on busy and reads HI/LO for MFHI/MFLO.

---
 rtl/mips_cpu_muldiv.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, one radix-2 step per cycle.
// Optional: define MULDIV_FAST_DIV0_EN to finish divide-by-zero in 2 cycles.
module mips_cpu_muldiv #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_acc;
  logic [31:0] r_opd;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic        w_b_zero;
  logic        w_sub;
  logic [32:0] w_x;
  logic [32:0] w_y;
  logic [33:0] w_sum;
  logic [63:0] w_prod;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic        w_last;

  // Operand magnitudes and signs; op[0]=0 selects the signed variants.
  assign w_sa     = ~op[0] & a[31];
  assign w_sb     = ~op[0] & b[31];
  assign w_abs_a  = w_sa ? (32'd0 - a) : a;
  assign w_abs_b  = w_sb ? (32'd0 - b) : b;
  assign w_b_zero = (b == 32'd0);

  // Shared adder: adds in MUL, trial-subtracts in DIV (carry out = no borrow).
  assign w_sub = (r_state == S_DIV);
  assign w_x   = w_sub ? r_acc[63:31] : {1'b0, r_acc[63:32]};
  assign w_y   = {1'b0, r_opd};
  assign w_sum = {1'b0, w_x} + {1'b0, (w_sub ? ~w_y : w_y)}
               + {33'd0, w_sub};

  // Sign correction applied in FIX.
  assign w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
  assign w_q    = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_r    = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
  assign w_last = (r_cnt == 5'(ITER - 1));

  // Sequencer: latch operands, iterate, correct signs, update HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_acc    <= 64'd0;
      r_opd    <= 32'd0;
      r_cnt    <= 5'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= 5'd0;
            r_is_div <= op[1];
            if (op[1]) begin
              r_opd   <= w_abs_b;
              r_neg_q <= (w_sa ^ w_sb) & ~w_b_zero;
              r_neg_r <= w_sa;
`ifdef MULDIV_FAST_DIV0_EN
              if (w_b_zero) begin
                r_acc   <= {w_abs_a, 32'hFFFF_FFFF};
                r_state <= S_FIX;
              end else begin
                r_acc   <= {32'd0, w_abs_a};
                r_state <= S_DIV;
              end
`else
              r_acc   <= {32'd0, w_abs_a};
              r_state <= S_DIV;
`endif
            end else begin
              r_acc   <= {32'd0, w_abs_b};
              r_opd   <= w_abs_a;
              r_neg_q <= w_sa ^ w_sb;
              r_neg_r <= 1'b0;
              r_state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          r_acc <= r_acc[0] ? {w_sum[32:0], r_acc[31:1]}
                            : {1'b0, r_acc[63:1]};
          r_cnt <= r_cnt + 5'd1;
          if (w_last) r_state <= S_FIX;
        end
        S_DIV: begin
          r_acc <= w_sum[33] ? {w_sum[31:0], r_acc[30:0], 1'b1}
                             : {r_acc[62:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_r;
            r_lo <= w_q;
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
